// File: rtl/muldiv_sequencer.sv
// Sequencer that lets the control unit share one multi-cycle multiplier and one
// multi-cycle divider: it clears, launches, watches and writes back HI/LO.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 63
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    op_valid,
    input  logic                    op_sel,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    op_ready,
    output logic                    mul_rst,
    output logic                    mul_start,
    output logic [DATA_WIDTH-1:0]   mul_multiplicand,
    output logic [DATA_WIDTH-1:0]   mul_multiplier,
    input  logic                    mul_done,
    input  logic [2*DATA_WIDTH-1:0] mul_product,
    output logic                    div_rst,
    output logic                    div_start,
    output logic [DATA_WIDTH-1:0]   div_dividend,
    output logic [DATA_WIDTH-1:0]   div_divisor,
    input  logic                    div_done,
    input  logic [DATA_WIDTH-1:0]   div_quotient,
    input  logic [DATA_WIDTH-1:0]   div_remainder,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo,
    output logic                    result_valid,
    output logic                    div_by_zero,
    output logic                    timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_WB,
        S_WB_DZ,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic                  rv_q, rv_d;
    logic                  dz_q, dz_d;
    logic                  to_q, to_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic                  unit_done;

    // Only the selected unit's done is ever looked at.
    assign unit_done = sel_q ? div_done : mul_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rv_q    <= 1'b0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rv_q    <= rv_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rv_d    = 1'b0;
        dz_d    = dz_q;
        to_d    = to_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    sel_d   = op_sel;
                    a_d     = op_a;
                    b_d     = op_b;
                    dz_d    = 1'b0;
                    to_d    = 1'b0;
                    state_d = (op_sel && (op_b == '0)) ? S_WB_DZ : S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_LAUNCH;
            S_LAUNCH: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                // A done arriving on the last watchdog cycle still counts.
                if (unit_done) begin
                    state_d = S_WB;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                if (sel_q) begin
                    hi_d = div_remainder;
                    lo_d = div_quotient;
                end else begin
                    hi_d = mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo_d = mul_product[DATA_WIDTH-1:0];
                end
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            S_WB_DZ: begin
                hi_d    = a_q;
                lo_d    = '1;
                dz_d    = 1'b1;
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                to_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Unit resets clear sticky done before launch and abandon a hung unit after a timeout.
    assign op_ready         = (state_q == S_IDLE);
    assign mul_rst          = reset | (!sel_q && ((state_q == S_CLEAR) || (state_q == S_ERR)));
    assign div_rst          = reset | ( sel_q && ((state_q == S_CLEAR) || (state_q == S_ERR)));
    assign mul_start        = !sel_q && (state_q == S_LAUNCH);
    assign div_start        =  sel_q && (state_q == S_LAUNCH);
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign div_dividend     = a_q;
    assign div_divisor      = b_q;
    assign hi               = hi_q;
    assign lo               = lo_q;
    assign result_valid     = rv_q;
    assign div_by_zero      = dz_q;
    assign timeout_err      = to_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with behavioural multiplier/divider models
// that raise a sticky done a fixed number of cycles after start.
module tb_muldiv_sequencer;

    localparam int W       = 32;
    localparam int TIMEOUT = 63;
    localparam int MUL_LAT = 34;
    localparam int DIV_LAT = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_sel = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          op_ready;
    logic          mul_rst, mul_start, div_rst, div_start;
    logic [W-1:0]  mul_multiplicand, mul_multiplier, div_dividend, div_divisor;
    logic          mul_done_m, div_done_m;
    logic [2*W-1:0] mul_prod_m;
    logic [W-1:0]  div_q_m, div_r_m;
    logic [W-1:0]  hi, lo;
    logic          result_valid, div_by_zero, timeout_err;
    logic          mul_hang = 1'b0;

    int checks = 0;
    int errors = 0;
    int mul_cnt, div_cnt;
    int n_mul_rst = 0, n_mul_start = 0, n_div_rst = 0, n_div_start = 0, n_rv = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_sel(op_sel), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mul_rst(mul_rst), .mul_start(mul_start),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_done(mul_done_m), .mul_product(mul_prod_m),
        .div_rst(div_rst), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done_m), .div_quotient(div_q_m), .div_remainder(div_r_m),
        .hi(hi), .lo(lo), .result_valid(result_valid),
        .div_by_zero(div_by_zero), .timeout_err(timeout_err)
    );

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return sx * sy;
    endfunction

    // Multiplier model: done visible MUL_LAT cycles after the start cycle.
    always @(posedge clk) begin
        if (mul_rst) begin
            mul_done_m <= 1'b0;
            mul_cnt    <= 0;
        end else if (mul_start) begin
            mul_cnt    <= MUL_LAT - 1;
            mul_prod_m <= smul(mul_multiplicand, mul_multiplier);
        end else if (mul_cnt > 1) begin
            mul_cnt <= mul_cnt - 1;
        end else if (mul_cnt == 1) begin
            mul_cnt <= 0;
            if (!mul_hang) mul_done_m <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (div_rst) begin
            div_done_m <= 1'b0;
            div_cnt    <= 0;
        end else if (div_start) begin
            div_cnt <= DIV_LAT - 1;
            if (div_divisor != '0) begin
                div_q_m <= $signed(div_dividend) / $signed(div_divisor);
                div_r_m <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                div_q_m <= '0;
                div_r_m <= '0;
            end
        end else if (div_cnt > 1) begin
            div_cnt <= div_cnt - 1;
        end else if (div_cnt == 1) begin
            div_cnt    <= 0;
            div_done_m <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (mul_rst)      n_mul_rst   <= n_mul_rst + 1;
            if (mul_start)    n_mul_start <= n_mul_start + 1;
            if (div_rst)      n_div_rst   <= n_div_rst + 1;
            if (div_start)    n_div_start <= n_div_start + 1;
            if (result_valid) n_rv        <= n_rv + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present a request at a negedge and return once it has been accepted (lat 0).
    task automatic present(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b);
        int i;
        @(negedge clk);
        op_valid = 1'b1;
        op_sel   = sel;
        op_a     = a;
        op_b     = b;
        i = 0;
        while (!op_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("accept_ready", 64'(op_ready), 64'(1));
    endtask

    task automatic wait_rv(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_valid && lat < 200);
        chk("rv_seen", 64'(result_valid), 64'(1));
    endtask

    typedef struct {
        logic          sel;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
        logic          dz;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, b_mr, b_ms, b_dr, b_ds, b_rv, bad;
        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_LAT + 4};
        vecs[1] = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, DIV_LAT + 4};
        vecs[2] = '{1'b1, 32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 2};
        vecs[3] = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'd1,         32'd0,         1'b0, MUL_LAT + 4};
        vecs[4] = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT + 4};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, MUL_LAT + 4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_op_ready", 64'(op_ready), 64'(1));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_rv", 64'(result_valid), 64'(0));
        chk("rst_dz", 64'(div_by_zero), 64'(0));
        chk("rst_to", 64'(timeout_err), 64'(0));
        chk("rst_mul_rst", 64'(mul_rst), 64'(1));
        chk("rst_div_rst", 64'(div_rst), 64'(1));
        chk("rst_starts", 64'({mul_start, div_start}), 64'(0));
        chk("rst_operands", 64'({mul_multiplicand, div_divisor}), 64'(0));
        reset = 1'b0;

        // Table-driven single operations
        for (int v = 0; v < 6; v++) begin
            present(vecs[v].sel, vecs[v].a, vecs[v].b);
            b_mr = n_mul_rst; b_ms = n_mul_start; b_dr = n_div_rst; b_ds = n_div_start; b_rv = n_rv;
            @(negedge clk);
            op_valid = 1'b0;
            chk("flags_cleared", 64'({div_by_zero, timeout_err}), 64'(0));
            chk("busy_not_ready", 64'(op_ready), 64'(0));
            wait_rv(lat);
            lat++;
            chk("latency", 64'(lat), 64'(vecs[v].lat));
            chk("hi", 64'(hi), 64'(vecs[v].hi));
            chk("lo", 64'(lo), 64'(vecs[v].lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(vecs[v].dz));
            $display("vec %0d sel=%0d a=%h b=%h hi=%h lo=%h dz=%0d lat=%0d",
                     v, vecs[v].sel, vecs[v].a, vecs[v].b, hi, lo, div_by_zero, lat);
            @(negedge clk);
            chk("rv_one_cycle", 64'(result_valid), 64'(0));
            chk("rv_count", 64'(n_rv - b_rv), 64'(1));
            chk("mul_rst_cycles", 64'(n_mul_rst - b_mr), 64'(vecs[v].sel ? 0 : 1));
            chk("mul_start_cycles", 64'(n_mul_start - b_ms), 64'(vecs[v].sel ? 0 : 1));
            chk("div_rst_cycles", 64'(n_div_rst - b_dr), 64'((vecs[v].sel && !vecs[v].dz) ? 1 : 0));
            chk("div_start_cycles", 64'(n_div_start - b_ds), 64'((vecs[v].sel && !vecs[v].dz) ? 1 : 0));
        end

        // Back-to-back multiplies with op_valid held high
        present(1'b0, 32'd7, 32'hFFFF_FFFD);
        @(negedge clk);
        op_a = 32'hFFFF_FFFE;
        op_b = 32'd3;
        bad = 0;
        lat = 1;
        while (!result_valid && lat < 200) begin
            if (op_ready) bad++;
            @(negedge clk);
            lat++;
        end
        chk("b2b_ready_low", 64'(bad), 64'(0));
        chk("b2b_first_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        chk("b2b_first_lo", 64'(lo), 64'(32'hFFFF_FFEB));
        chk("b2b_ready_at_rv", 64'(op_ready), 64'(1));
        @(negedge clk);
        op_valid = 1'b0;
        chk("b2b_fresh_mul_rst", 64'({mul_rst, mul_start}), 64'(2'b10));
        @(negedge clk);
        chk("b2b_second_start", 64'({mul_rst, mul_start}), 64'(2'b01));
        wait_rv(lat);
        chk("b2b_second_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        chk("b2b_second_lo", 64'(lo), 64'(32'hFFFF_FFFA));
        $display("b2b second hi=%h lo=%h", hi, lo);

        // Watchdog timeout with a hung multiplier
        mul_hang = 1'b1;
        present(1'b0, 32'd3, 32'd4);
        b_mr = n_mul_rst; b_rv = n_rv;
        lat = 0;
        do begin
            @(negedge clk);
            op_valid = 1'b0;
            lat++;
        end while (!op_ready && lat < 200);
        chk("to_latency", 64'(lat), 64'(TIMEOUT + 4));
        chk("to_flag", 64'(timeout_err), 64'(1));
        chk("to_no_rv", 64'(n_rv - b_rv), 64'(0));
        chk("to_hi_kept", 64'(hi), 64'(32'hFFFF_FFFF));
        chk("to_lo_kept", 64'(lo), 64'(32'hFFFF_FFFA));
        chk("to_mul_rst_cycles", 64'(n_mul_rst - b_mr), 64'(2));
        $display("timeout lat=%0d timeout_err=%0d", lat, timeout_err);
        mul_hang = 1'b0;
        present(1'b1, 32'd9, 32'd4);
        @(negedge clk);
        op_valid = 1'b0;
        chk("to_cleared", 64'(timeout_err), 64'(0));
        wait_rv(lat);
        chk("after_to_lo", 64'(lo), 64'(2));
        chk("after_to_hi", 64'(hi), 64'(1));
        $display("after timeout div hi=%h lo=%h", hi, lo);

        // Reset pulsed mid-WAIT
        present(1'b0, 32'd7, 32'hFFFF_FFFD);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        b_rv = n_rv;
        reset = 1'b1;
        #1;
        chk("midrst_hi", 64'(hi), 64'(0));
        chk("midrst_lo", 64'(lo), 64'(0));
        chk("midrst_mul_rst", 64'(mul_rst), 64'(1));
        chk("midrst_idle", 64'(op_ready), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", 64'(op_ready), 64'(1));
        chk("midrst_units_released", 64'({mul_rst, mul_start}), 64'(0));
        for (int i = 0; i < 50; i++) @(negedge clk);
        chk("midrst_no_rv", 64'(n_rv - b_rv), 64'(0));
        $display("mid-op reset hi=%h lo=%h op_ready=%0d", hi, lo, op_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
